spi_flash_responder: RTL and testbench

- Synthesizable SPI mode-0 flash responder (target) that serves bitstream bytes from an on-chip memory port to an external SPI initiator. It is the far end of the FPGA bitstream-load SPI link.
- Used in emulation and loopback builds in place of a behavioural flash model. Lets the configuration SPI initiator be exercised against real RTL.
- SPI pins are asynchronous to fpga_clk. They are oversampled, and fpga_clk must be ≥16× SCLK.

---
 rtl/spi_flash_pkg.sv | 20 ++
 rtl/spi_flash_responder_sync.sv | 48 ++++
 rtl/spi_flash_responder.sv | 203 ++++++++++++++++++++
 tb/tb_spi_flash_responder.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_pkg.sv
// Shared opcodes, FSM states and constants for the SPI flash responder.
package spi_flash_pkg;

  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_FAST_READ = 8'h0B;
  localparam logic [7:0] OP_RDID      = 8'h9F;

  localparam int DUMMY_CYCLES = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_ID,
    ST_IGNORE
  } state_t;

endpackage

// File: rtl/spi_flash_responder_sync.sv
// Synchronizes the SPI pins into the fabric clock and produces SCLK/CS edge strobes.
module spi_flash_responder_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk,
  input  logic cs_n,
  input  logic mosi,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_fall,
  output logic cs_high,
  output logic mosi_s
);

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_d;
  logic                   cs_d;
  logic                   sclk_s;

  // CS resets to the deasserted level so no false edge appears out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_d    <= sclk_s;
      cs_d      <= cs_high;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_high   = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_fall   = ~cs_high & cs_d;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash target serving bytes from a memory port (READ, RDID).
// Define SPI_FAST_READ_EN to also accept FAST_READ (0x0B) with 8 dummy clocks.
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter int          ADDR_W      = 24,
  parameter int          SYNC_STAGES = 2,
  parameter logic [23:0] JEDEC_ID    = 24'hEF4018
) (
  input  logic              fpga_clk,
  input  logic              fpga_rst_n,
  input  logic              spi_sclk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_rvalid,
  output logic              busy,
  output logic              underrun,
  output logic              cmd_error
);

  localparam int CNT_W = (ADDR_W > 8) ? $clog2(ADDR_W) : 3;

  logic              sclk_rise, sclk_fall, cs_fall, cs_high, mosi_s;
  state_t            state, next_state;
  logic              bad_op;
  logic [CNT_W-1:0]  bit_cnt;
  logic [ADDR_W-1:0] shift_sr;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] addr_next;
  logic [7:0]        rx_byte;
  logic [7:0]        tx_sr;
  logic [2:0]        tx_cnt;
  logic [1:0]        id_idx;
  logic [7:0]        id_byte;
  logic [7:0]        load_byte;
  logic [7:0]        pf_data;
  logic              pf_valid;
  logic              req_pending;
`ifdef SPI_FAST_READ_EN
  logic              fast_q;
`endif

  spi_flash_responder_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (fpga_clk),
    .rst_n     (fpga_rst_n),
    .sclk      (spi_sclk),
    .cs_n      (spi_cs_n),
    .mosi      (spi_mosi),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .cs_fall   (cs_fall),
    .cs_high   (cs_high),
    .mosi_s    (mosi_s)
  );

  assign busy      = ~cs_high;
  assign rx_byte   = {shift_sr[6:0], mosi_s};
  assign addr_next = {shift_sr[ADDR_W-2:0], mosi_s};

  always_comb begin
    id_byte = 8'hFF;
    case (id_idx)
      2'd0:    id_byte = JEDEC_ID[23:16];
      2'd1:    id_byte = JEDEC_ID[15:8];
      2'd2:    id_byte = JEDEC_ID[7:0];
      default: id_byte = 8'hFF;
    endcase
    load_byte = id_byte;
    if (state == ST_DATA) load_byte = pf_valid ? pf_data : 8'hFF;
  end

  always_ff @(posedge fpga_clk or negedge fpga_rst_n) begin
    if (!fpga_rst_n) state <= ST_IDLE;
    else             state <= next_state;
  end

  // CS deassert overrides any SCLK edge seen in the same cycle
  always_comb begin
    next_state = state;
    bad_op     = 1'b0;
    if (cs_high) begin
      next_state = ST_IDLE;
    end else if (cs_fall) begin
      next_state = ST_CMD;
    end else if (sclk_rise) begin
      unique case (state)
        ST_CMD:
          if (bit_cnt == CNT_W'(7)) begin
            case (rx_byte)
              OP_READ:      next_state = ST_ADDR;
`ifdef SPI_FAST_READ_EN
              OP_FAST_READ: next_state = ST_ADDR;
`endif
              OP_RDID:      next_state = ST_ID;
              default: begin
                next_state = ST_IGNORE;
                bad_op     = 1'b1;
              end
            endcase
          end
        ST_ADDR:
          if (bit_cnt == CNT_W'(ADDR_W - 1)) begin
`ifdef SPI_FAST_READ_EN
            next_state = fast_q ? ST_DUMMY : ST_DATA;
`else
            next_state = ST_DATA;
`endif
          end
`ifdef SPI_FAST_READ_EN
        ST_DUMMY:
          if (bit_cnt == CNT_W'(DUMMY_CYCLES - 1)) next_state = ST_DATA;
`endif
        default: next_state = state;
      endcase
    end
  end

  always_ff @(posedge fpga_clk or negedge fpga_rst_n) begin
    if (!fpga_rst_n) begin
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      underrun    <= 1'b0;
      cmd_error   <= 1'b0;
      bit_cnt     <= '0;
      shift_sr    <= '0;
      addr        <= '0;
      tx_sr       <= '0;
      tx_cnt      <= '0;
      id_idx      <= '0;
      pf_data     <= '0;
      pf_valid    <= 1'b0;
      req_pending <= 1'b0;
`ifdef SPI_FAST_READ_EN
      fast_q      <= 1'b0;
`endif
    end else begin
      mem_req   <= 1'b0;
      cmd_error <= bad_op;
      if (mem_rvalid && req_pending) begin
        pf_data     <= mem_rdata;
        pf_valid    <= 1'b1;
        req_pending <= 1'b0;
      end
      if (cs_high) begin
        spi_miso    <= 1'b0;
        spi_miso_oe <= 1'b0;
        pf_valid    <= 1'b0;
        req_pending <= 1'b0;
        bit_cnt     <= '0;
      end else if (cs_fall) begin
        bit_cnt  <= '0;
        tx_cnt   <= '0;
        id_idx   <= '0;
        underrun <= 1'b0;
      end else begin
        if (sclk_rise && (state == ST_CMD || state == ST_ADDR || state == ST_DUMMY)) begin
          shift_sr <= addr_next;
          bit_cnt  <= (next_state != state) ? '0 : bit_cnt + 1'b1;
        end
`ifdef SPI_FAST_READ_EN
        if (state == ST_CMD && next_state == ST_ADDR) fast_q <= (rx_byte == OP_FAST_READ);
`endif
        if (state == ST_ADDR && next_state != ST_ADDR) begin
          addr        <= addr_next;
          mem_req     <= 1'b1;
          mem_addr    <= addr_next;
          req_pending <= 1'b1;
          pf_valid    <= 1'b0;
        end
        // Byte boundary: drain the prefetch buffer and request the next byte
        if (sclk_fall && (state == ST_DATA || state == ST_ID)) begin
          spi_miso_oe <= 1'b1;
          tx_cnt      <= tx_cnt + 3'd1;
          if (tx_cnt == 3'd0) begin
            spi_miso <= load_byte[7];
            tx_sr    <= {load_byte[6:0], 1'b0};
            if (state == ST_DATA) begin
              underrun    <= underrun | ~pf_valid;
              pf_valid    <= 1'b0;
              addr        <= addr + 1'b1;
              mem_req     <= 1'b1;
              mem_addr    <= addr + 1'b1;
              req_pending <= 1'b1;
            end else if (id_idx != 2'd3) begin
              id_idx <= id_idx + 2'd1;
            end
          end else begin
            spi_miso <= tx_sr[7];
            tx_sr    <= {tx_sr[6:0], 1'b0};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: READ, wrap, RDID, bad opcode, abort, underrun.
// Honours SPI_FAST_READ_EN to exercise FAST_READ or its rejection.
module tb_spi_flash_responder;

  localparam int ADDR_W = 24;
  localparam int HALF   = 8;

  logic              fpga_clk = 1'b0;
  logic              fpga_rst_n;
  logic              spi_sclk;
  logic              spi_cs_n;
  logic              spi_mosi;
  logic              spi_miso;
  logic              spi_miso_oe;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic              mem_rvalid;
  logic              busy;
  logic              underrun;
  logic              cmd_error;

  int n_checks = 0;
  int n_fail   = 0;
  int mem_lat  = 2;

  logic [63:0]       pipe_v;
  logic [ADDR_W-1:0] pipe_a [64];
  logic [ADDR_W-1:0] req_log [256];
  int                req_cnt   = 0;
  int                err_total = 0;
  int                oe_total  = 0;

  spi_flash_responder dut (
    .fpga_clk    (fpga_clk),
    .fpga_rst_n  (fpga_rst_n),
    .spi_sclk    (spi_sclk),
    .spi_cs_n    (spi_cs_n),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .mem_rvalid  (mem_rvalid),
    .busy        (busy),
    .underrun    (underrun),
    .cmd_error   (cmd_error)
  );

  always #5 fpga_clk = ~fpga_clk;

  // Memory stub: byte[i] = i ^ A5, returned mem_lat cycles after the request
  always @(posedge fpga_clk) begin
    if (!fpga_rst_n) begin
      pipe_v     <= '0;
      mem_rvalid <= 1'b0;
      mem_rdata  <= '0;
    end else begin
      pipe_v <= {pipe_v[62:0], mem_req};
      for (int i = 63; i > 0; i--) pipe_a[i] <= pipe_a[i-1];
      pipe_a[0]  <= mem_addr;
      mem_rvalid <= pipe_v[mem_lat-2];
      mem_rdata  <= pipe_a[mem_lat-2][7:0] ^ 8'hA5;
    end
  end

  always @(posedge fpga_clk) begin
    if (fpga_rst_n) begin
      if (mem_req && req_cnt < 256) begin
        req_log[req_cnt] <= mem_addr;
        req_cnt <= req_cnt + 1;
      end
      if (cmd_error)   err_total <= err_total + 1;
      if (spi_miso_oe) oe_total  <= oe_total + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge fpga_clk);
    #1;
  endtask

  task automatic spi_bit(input logic b, output logic r);
    spi_mosi = b;
    wait_clk(HALF);
    spi_sclk = 1'b1;
    r = spi_miso;
    wait_clk(HALF);
    spi_sclk = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] tx, output logic [7:0] rx);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], r);
      rx[i] = r;
    end
  endtask

  task automatic send_addr(input logic [ADDR_W-1:0] a);
    logic r;
    for (int i = ADDR_W - 1; i >= 0; i--) spi_bit(a[i], r);
  endtask

  task automatic cs_begin();
    spi_cs_n = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic cs_end();
    wait_clk(HALF);
    spi_cs_n = 1'b1;
    wait_clk(2 * HALF);
  endtask

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] rx;
    logic       r;
    int         base;
    int         oe0;
    int         err0;

    fpga_rst_n = 1'b0;
    spi_sclk   = 1'b0;
    spi_cs_n   = 1'b1;
    spi_mosi   = 1'b0;
    wait_clk(5);
    checkOutput("rst_miso", 32'(spi_miso), 32'h0);
    checkOutput("rst_oe", 32'(spi_miso_oe), 32'h0);
    checkOutput("rst_req", 32'(mem_req), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_underrun", 32'(underrun), 32'h0);
    checkOutput("rst_cmd_error", 32'(cmd_error), 32'h0);
    fpga_rst_n = 1'b1;
    wait_clk(10);

    // READ at 0x000010, four bytes
    base = req_cnt;
    cs_begin();
    checkOutput("read_busy", 32'(busy), 32'h1);
    applyStimulus(8'h03, rx);
    send_addr(24'h000010);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(8'h00, rx);
      checkOutput($sformatf("read_byte%0d", i), 32'(rx), 32'((8'h10 + i) ^ 8'hA5));
    end
    cs_end();
    for (int i = 0; i < 5; i++)
      checkOutput($sformatf("read_addr%0d", i), 32'(req_log[base + i]), 32'(24'h10 + i));
    checkOutput("read_underrun", 32'(underrun), 32'h0);
    checkOutput("read_oe_after", 32'(spi_miso_oe), 32'h0);
    checkOutput("read_miso_after", 32'(spi_miso), 32'h0);
    checkOutput("read_busy_after", 32'(busy), 32'h0);

    // Address wrap past the top of the space
    base = req_cnt;
    cs_begin();
    applyStimulus(8'h03, rx);
    send_addr(24'hFFFFFE);
    applyStimulus(8'h00, rx);
    checkOutput("wrap_byte0", 32'(rx), 32'h5B);
    applyStimulus(8'h00, rx);
    checkOutput("wrap_byte1", 32'(rx), 32'h5A);
    applyStimulus(8'h00, rx);
    checkOutput("wrap_byte2", 32'(rx), 32'hA5);
    cs_end();
    checkOutput("wrap_addr2", 32'(req_log[base + 2]), 32'h000000);

    // RDID returns the JEDEC ID then 0xFF filler, never touching memory
    base = req_cnt;
    cs_begin();
    applyStimulus(8'h9F, rx);
    applyStimulus(8'h00, rx); checkOutput("rdid_b0", 32'(rx), 32'hEF);
    applyStimulus(8'h00, rx); checkOutput("rdid_b1", 32'(rx), 32'h40);
    applyStimulus(8'h00, rx); checkOutput("rdid_b2", 32'(rx), 32'h18);
    applyStimulus(8'h00, rx); checkOutput("rdid_b3", 32'(rx), 32'hFF);
    applyStimulus(8'h00, rx); checkOutput("rdid_b4", 32'(rx), 32'hFF);
    cs_end();
    checkOutput("rdid_no_req", 32'(req_cnt - base), 32'h0);

    // Unsupported opcode: one cmd_error cycle, pad never enabled
    oe0  = oe_total;
    err0 = err_total;
    cs_begin();
    applyStimulus(8'h05, rx);
    applyStimulus(8'h00, rx);
    applyStimulus(8'h00, rx);
    cs_end();
    checkOutput("badop_err_cycles", 32'(err_total - err0), 32'h1);
    checkOutput("badop_oe_cycles", 32'(oe_total - oe0), 32'h0);
    checkOutput("badop_miso", 32'(rx), 32'h0);

    // Abort after 13 address bits, then a clean READ at 0x000020
    cs_begin();
    applyStimulus(8'h03, rx);
    for (int i = 0; i < 13; i++) spi_bit(1'b1, r);
    cs_end();
    base = req_cnt;
    cs_begin();
    applyStimulus(8'h03, rx);
    send_addr(24'h000020);
    applyStimulus(8'h00, rx);
    checkOutput("abort_byte0", 32'(rx), 32'h85);
    applyStimulus(8'h00, rx);
    checkOutput("abort_byte1", 32'(rx), 32'h84);
    cs_end();
    checkOutput("abort_first_addr", 32'(req_log[base]), 32'h000020);
    checkOutput("abort_underrun", 32'(underrun), 32'h0);

    // Slow memory: first byte underruns, flag clears on next select
    mem_lat = 40;
    cs_begin();
    applyStimulus(8'h03, rx);
    send_addr(24'h000010);
    applyStimulus(8'h00, rx);
    checkOutput("under_byte0", 32'(rx), 32'hFF);
    cs_end();
    checkOutput("under_flag", 32'(underrun), 32'h1);
    wait_clk(70);
    mem_lat = 2;
    wait_clk(10);
    cs_begin();
    checkOutput("under_cleared", 32'(underrun), 32'h0);
    applyStimulus(8'h03, rx);
    send_addr(24'h000030);
    applyStimulus(8'h00, rx);
    checkOutput("under_recover", 32'(rx), 32'h95);
    cs_end();

`ifdef SPI_FAST_READ_EN
    cs_begin();
    applyStimulus(8'h0B, rx);
    send_addr(24'h000010);
    applyStimulus(8'h00, rx);
    applyStimulus(8'h00, rx);
    checkOutput("fast_byte0", 32'(rx), 32'hB5);
    applyStimulus(8'h00, rx);
    checkOutput("fast_byte1", 32'(rx), 32'hB4);
    cs_end();
`else
    oe0  = oe_total;
    err0 = err_total;
    cs_begin();
    applyStimulus(8'h0B, rx);
    send_addr(24'h000010);
    applyStimulus(8'h00, rx);
    cs_end();
    checkOutput("fast_rejected_err", 32'(err_total - err0), 32'h1);
    checkOutput("fast_rejected_oe", 32'(oe_total - oe0), 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
